// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : switch_debouncer
// Description : Multi-channel switch/button conditioner. Each raw input goes
//               through a two-flop synchroniser into the clk domain. A
//               per-channel stability counter then filters contact bounce.
//               The block drives clean registered levels plus single-cycle
//               rise/fall strobes.
// Ports       : clk   - system clock, rising-edge active
//               rst   - asynchronous, active-low reset
//               din   - [WIDTH] raw levels, asynchronous to clk
//               dout  - [WIDTH] debounced, registered levels
//               rise  - [WIDTH] one-cycle strobe on dout 0->1
//               fall  - [WIDTH] one-cycle strobe on dout 1->0
// Revision    : 1.0 - initial release
// ============================================================================
module switch_debouncer #(
    parameter int WIDTH   = 4,
    parameter int CNT_MAX = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    // Counter only has to reach CNT_MAX-1; keep at least one bit so that
    // CNT_MAX = 1 still elaborates.
    localparam int                C_CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(CNT_MAX - 1);

    logic [WIDTH-1:0]   r_s1;
    logic [WIDTH-1:0]   r_s2;
    logic [WIDTH-1:0]   r_dout;
    logic [WIDTH-1:0]   r_rise;
    logic [WIDTH-1:0]   r_fall;
    logic [C_CNT_W-1:0] r_cnt [WIDTH];

    logic [WIDTH-1:0]   w_pending;
    logic [WIDTH-1:0]   w_update;

    // A channel is pending whenever the synchronised level disagrees with the
    // accepted level. It commits once it has disagreed for CNT_MAX cycles.
    always_comb begin
        w_pending = r_s2 ^ r_dout;
        w_update  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_update[i] = w_pending[i] && (r_cnt[i] == C_CNT_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_dout <= '0;
            r_rise <= '0;
            r_fall <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            // Two-stage synchroniser; only r_s2 is used downstream.
            r_s1 <= din;
            r_s2 <= r_s1;

            // A single agreeing cycle clears the count, so any bounce
            // restarts the full wait. The count stops at C_CNT_LAST and
            // never wraps.
            for (int i = 0; i < WIDTH; i++) begin
                if (!w_pending[i] || w_update[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + C_CNT_W'(1);
                end
            end

            r_dout <= (r_dout & ~w_update) | (r_s2 & w_update);
            // Strobes are registered together with dout, so they line up
            // with the first cycle that shows the new level.
            r_rise <= w_update & r_s2;
            r_fall <= w_update & ~r_s2;
        end
    end

    assign dout = r_dout;
    assign rise = r_rise;
    assign fall = r_fall;

endmodule
`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_debouncer
// Description : Self-checking bench for switch_debouncer (WIDTH=4, CNT_MAX=4).
//               A sliding-window reference model is compared against the DUT
//               every cycle. Directed scenarios pin literal values at
//               specific edges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_debouncer;

    localparam int WIDTH   = 4;
    localparam int CNT_MAX = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] din = '0;
    logic [WIDTH-1:0] dout;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    int n_checks = 0;
    int n_fail   = 0;

    switch_debouncer #(
        .WIDTH   (WIDTH),
        .CNT_MAX (CNT_MAX)
    ) u_dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .dout (dout),
        .rise (rise),
        .fall (fall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. The model keeps the synchronised level seen before
    // each of the last CNT_MAX edges. A channel's level is accepted when
    // every one of those samples disagrees with the current output.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] m_s1   = '0;
    logic [WIDTH-1:0] m_s2   = '0;
    logic [WIDTH-1:0] m_dout = '0;
    logic [WIDTH-1:0] m_rise = '0;
    logic [WIDTH-1:0] m_fall = '0;
    logic [WIDTH-1:0] m_win [CNT_MAX-1];   // m_win[k]: sync level before edge E-1-k

    function automatic logic [WIDTH-1:0] model_accept();
        logic [WIDTH-1:0] acc;
        acc = m_s2 ^ m_dout;
        for (int k = 0; k < CNT_MAX-1; k++) begin
            acc = acc & (m_win[k] ^ m_dout);
        end
        return acc;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_s1   <= '0;
            m_s2   <= '0;
            m_dout <= '0;
            m_rise <= '0;
            m_fall <= '0;
            for (int k = 0; k < CNT_MAX-1; k++) m_win[k] <= '0;
        end else begin
            m_dout <= (m_dout & ~model_accept()) | (m_s2 & model_accept());
            m_rise <= model_accept() & m_s2;
            m_fall <= model_accept() & ~m_s2;
            m_s1   <= din;
            m_s2   <= m_s1;
            m_win[0] <= m_s2;
            for (int k = 1; k < CNT_MAX-1; k++) m_win[k] <= m_win[k-1];
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("model_dout", 32'(dout), 32'(m_dout));
        check("model_rise", 32'(rise), 32'(m_rise));
        check("model_fall", 32'(fall), 32'(m_fall));
        check("strobe_excl", 32'(rise & fall), 32'd0);
    end

    // Strobe pulse counters, used to check "exactly one" and "never".
    int rise_cnt [WIDTH];
    int fall_cnt [WIDTH];
    initial for (int c = 0; c < WIDTH; c++) begin rise_cnt[c] = 0; fall_cnt[c] = 0; end
    always @(negedge clk) begin
        for (int c = 0; c < WIDTH; c++) begin
            rise_cnt[c] <= rise_cnt[c] + int'(rise[c]);
            fall_cnt[c] <= fall_cnt[c] + int'(fall[c]);
        end
    end

    task automatic drive(input logic [WIDTH-1:0] v);
        @(negedge clk);
        din = v;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Absolute watchdog: the directed sequence is a few hundred cycles.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int snap_r, snap_f;

        // ---------------- Reset with inputs high ----------------
        din = 4'hF;
        #1 rst = 1'b0;
        tick(3);
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_rise", 32'(rise), 32'h0);
        check("rst_fall", 32'(fall), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick(5);                                   // after R4
        check("rel_dout_e4", 32'(dout), 32'h0);
        tick(1);                                   // after R5
        check("rel_dout_e5", 32'(dout), 32'hF);
        check("rel_rise_e5", 32'(rise), 32'hF);
        tick(1);
        check("rel_rise_e6", 32'(rise), 32'h0);

        // ---------------- Clean press on channel 0 ----------------
        drive(4'h0);
        tick(10);
        check("idle_dout", 32'(dout), 32'h0);
        drive(4'h1);
        tick(5);
        check("press_dout_e4", 32'(dout), 32'h0);
        tick(1);
        check("press_dout_e5", 32'(dout), 32'h1);
        check("press_rise_e5", 32'(rise), 32'h1);
        tick(1);
        check("press_rise_e6", 32'(rise), 32'h0);
        check("press_dout_e6", 32'(dout), 32'h1);

        // ---------------- Bounce on channel 1 ----------------
        snap_r = rise_cnt[1];
        drive(4'h3);
        drive(4'h1);
        drive(4'h3);
        drive(4'h1);
        drive(4'h3);                               // final stable 1
        tick(5);
        check("bounce_dout_e4", 32'(dout), 32'h1);
        tick(1);
        check("bounce_dout_e5", 32'(dout), 32'h3);
        check("bounce_rise_e5", 32'(rise), 32'h2);
        tick(6);
        check("bounce_rise_count", 32'(rise_cnt[1] - snap_r), 32'd1);

        // ---------------- Short glitch on channel 2 ----------------
        snap_r = rise_cnt[2];
        snap_f = fall_cnt[2];
        drive(4'h7);
        drive(4'h7);
        drive(4'h7);
        drive(4'h3);
        tick(12);
        check("glitch_dout", 32'(dout), 32'h3);
        check("glitch_rise_count", 32'(rise_cnt[2] - snap_r), 32'd0);
        check("glitch_fall_count", 32'(fall_cnt[2] - snap_f), 32'd0);

        // ---------------- Simultaneous rise and fall ----------------
        drive(4'hC);
        tick(5);
        check("simul_dout_e4", 32'(dout), 32'h3);
        tick(1);
        check("simul_dout_e5", 32'(dout), 32'hC);
        check("simul_rise_e5", 32'(rise), 32'hC);
        check("simul_fall_e5", 32'(fall), 32'h3);
        tick(1);
        check("simul_fall_e6", 32'(fall), 32'h0);

        // ---------------- Reset mid-PENDING on channel 0 ----------------
        snap_r = rise_cnt[0];
        drive(4'hD);
        tick(4);                                   // just after E3
        rst = 1'b0;
        #1;
        check("midrst_async_dout", 32'(dout), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick(5);                                   // after R4
        check("midrst_dout_e4", 32'(dout), 32'h0);
        tick(1);                                   // after R5
        check("midrst_dout_e5", 32'(dout), 32'hD);
        check("midrst_rise_e5", 32'(rise), 32'hD);
        tick(4);
        check("midrst_rise_count", 32'(rise_cnt[0] - snap_r), 32'd1);
        check("midrst_dout_hold", 32'(dout), 32'hD);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
